// File: rtl/seg_capture_pkg.sv
// Shared display constants: segment patterns, digit codes, capture FSM states.
// Segment bit0 is 'a' through bit6 'g', active high.
package seg_capture_pkg;

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_e;

    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] ERR   = 4'hE;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_capture_seg_to_bcd.sv
// Combinational seven-segment pattern to digit-code lookup.
// Unknown patterns yield ERR with err raised.
module seg_to_bcd
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = ERR;
        err  = 1'b0;
        unique case (1'b1)
            (seg == SEG_0):     code = 4'h0;
            (seg == SEG_1):     code = 4'h1;
            (seg == SEG_2):     code = 4'h2;
            (seg == SEG_3):     code = 4'h3;
            (seg == SEG_4):     code = 4'h4;
            (seg == SEG_5):     code = 4'h5;
            (seg == SEG_6):     code = 4'h6;
            (seg == SEG_7):     code = 4'h7;
            (seg == SEG_8):     code = 4'h8;
            (seg == SEG_9):     code = 4'h9;
            (seg == SEG_BLANK): code = BLANK;
            default: begin
                code = ERR;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed seven-segment display into a frame of digit codes
// and presents it to a consumer with a valid/ready handshake.
module seg_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic              frame_ready,
    output logic [4*NDIG-1:0] frame_bcd,
    output logic              frame_valid,
    output logic              code_err,
    output logic              overrun
);
    import seg_capture_pkg::*;

    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYC - 2);
    localparam logic [7:0] SAT_CNT = 8'(STABLE_CYC);

    logic [6:0]      seg_q1, seg_q2, seg_prev;
    logic [NDIG-1:0] dig_q1, dig_q2, dig_prev;
    logic [7:0]      cnt;
    logic            same, onehot, accept;
    logic [3:0]      dec_code;
    logic            dec_err;
    logic [NDIG-1:0] acc_mask;

    logic [3:0]      slot_code [NDIG];
    logic [NDIG-1:0] slot_err, flags;
    logic [3:0]      nxt_code [NDIG];
    logic [NDIG-1:0] nxt_err, nxt_flag;
    logic [4*NDIG-1:0] frame_nxt;
    logic            all_next, hit_set;
    state_e          state;

    seg_to_bcd u_dec (
        .seg  (seg_q2),
        .code (dec_code),
        .err  (dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q1   <= '0;
            seg_q2   <= '0;
            seg_prev <= '0;
            dig_q1   <= '0;
            dig_q2   <= '0;
            dig_prev <= '0;
        end else begin
            seg_q1   <= seg_in;
            seg_q2   <= seg_q1;
            seg_prev <= seg_q2;
            dig_q1   <= dig_sel;
            dig_q2   <= dig_q1;
            dig_prev <= dig_q2;
        end
    end

    assign same   = (seg_q2 == seg_prev) && (dig_q2 == dig_prev);
    assign onehot = $onehot(dig_q2);
    // Fires once per stable run: the count passes ACC_CNT exactly once.
    assign accept = same && onehot && (cnt == ACC_CNT);
    assign acc_mask = accept ? dig_q2 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!same || !onehot) begin
            cnt <= '0;
        end else if (cnt < SAT_CNT) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        frame_nxt = '0;
        for (int i = 0; i < NDIG; i++) begin
            nxt_code[i] = acc_mask[i] ? dec_code : slot_code[i];
            nxt_err[i]  = acc_mask[i] ? dec_err : slot_err[i];
            frame_nxt[4*i +: 4] = nxt_code[i];
        end
        nxt_flag = flags | acc_mask;
    end

    assign all_next = &nxt_flag;
    assign hit_set  = |(acc_mask & flags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                slot_code[i] <= BLANK;
            end
            slot_err    <= '0;
            flags       <= '0;
            state       <= COLLECT;
            frame_valid <= 1'b0;
            frame_bcd   <= {NDIG{BLANK}};
            code_err    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            slot_code <= nxt_code;
            slot_err  <= nxt_err;
            unique case (state)
                COLLECT: begin
                    if (all_next) begin
                        frame_bcd   <= frame_nxt;
                        code_err    <= |nxt_err;
                        flags       <= '0;
                        frame_valid <= 1'b1;
                        state       <= PRESENT;
                    end else begin
                        flags <= nxt_flag;
                    end
                end
                PRESENT: begin
                    if (hit_set) begin
                        overrun <= 1'b1;
                    end
                    // A completed set at handshake time goes straight out.
                    if (frame_ready && all_next) begin
                        frame_bcd <= frame_nxt;
                        code_err  <= |nxt_err;
                        flags     <= '0;
                    end else if (frame_ready) begin
                        flags       <= nxt_flag;
                        frame_valid <= 1'b0;
                        state       <= COLLECT;
                    end else begin
                        flags <= nxt_flag;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with an expected-frame scoreboard.
// Frames are queued when scanned and popped when frame_valid shows.
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        frame_ready;
    logic [15:0] frame_bcd;
    logic        frame_valid;
    logic        code_err;
    logic        overrun;

    int n_assert = 0;
    int n_fail   = 0;
    logic [16:0] sb [$];

    seg_capture #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .frame_ready (frame_ready),
        .frame_bcd   (frame_bcd),
        .frame_valid (frame_valid),
        .code_err    (code_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat,
                        input int hold);
        dig_sel = 4'(1 << d);
        seg_in  = pat;
        tick(hold);
    endtask

    task automatic idle(input int n);
        dig_sel = '0;
        seg_in  = '0;
        tick(n);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3,
                        input int hold);
        show(0, p0, hold);
        show(1, p1, hold);
        show(2, p2, hold);
        show(3, p3, hold);
        idle(4);
    endtask

    task automatic expect_frame(input int budget);
        int n;
        logic [16:0] e;
        n = 0;
        while (frame_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("frame_valid_wait", 32'(frame_valid), 32'd1);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_empty: observed frame %h expected none",
                   frame_bcd);
        end else begin
            e = sb.pop_front();
            chk("frame_bcd", 32'(frame_bcd), 32'(e[15:0]));
            chk("code_err", 32'(code_err), 32'(e[16]));
        end
    endtask

    task automatic handshake();
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        seg_in = '0;
        dig_sel = '0;
        frame_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_bcd", 32'(frame_bcd), 32'hFFFF);
        chk("rst_err", 32'(code_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(2);

        // "1234": digit0=4 .. digit3=1
        sb.push_back({1'b0, 16'h1234});
        scan(7'h66, 7'h4F, 7'h5B, 7'h06, 8);
        expect_frame(20);
        chk("ovr_clean", 32'(overrun), 32'd0);
        handshake();
        chk("hs_drop", 32'(frame_valid), 32'd0);

        // 3-cycle holds never reach stability
        scan(7'h7F, 7'h07, 7'h7D, 7'h6D, 3);
        idle(10);
        chk("short_hold", 32'(frame_valid), 32'd0);

        sb.push_back({1'b1, 16'h1E34});
        scan(7'h66, 7'h4F, 7'h49, 7'h06, 8);
        expect_frame(20);
        handshake();
        sb.push_back({1'b0, 16'h1F34});
        scan(7'h66, 7'h4F, 7'h00, 7'h06, 8);
        expect_frame(20);
        handshake();

        // pending frame while two more scans arrive
        sb.push_back({1'b0, 16'h1234});
        scan(7'h66, 7'h4F, 7'h5B, 7'h06, 8);
        expect_frame(20);
        sb.push_back({1'b0, 16'h5678});
        scan(7'h7F, 7'h07, 7'h7D, 7'h6D, 8);
        chk("ovr_not_yet", 32'(overrun), 32'd0);
        scan(7'h7F, 7'h07, 7'h7D, 7'h6D, 8);
        chk("held_bcd", 32'(frame_bcd), 32'h1234);
        chk("held_valid", 32'(frame_valid), 32'd1);
        chk("ovr_set", 32'(overrun), 32'd1);
        handshake();
        expect_frame(0);
        handshake();
        chk("hs_drop2", 32'(frame_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // multi-hot select, then only digits 2 and 3
        dig_sel = 4'b0011;
        seg_in  = 7'h06;
        tick(10);
        show(2, 7'h3F, 8);
        show(3, 7'h6F, 8);
        idle(6);
        chk("multihot", 32'(frame_valid), 32'd0);

        rst = 1'b1;
        tick(2);
        chk("mid_rst_valid", 32'(frame_valid), 32'd0);
        chk("mid_rst_bcd", 32'(frame_bcd), 32'hFFFF);
        chk("mid_rst_err", 32'(code_err), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(2);
        show(0, 7'h07, 8);
        show(1, 7'h7F, 8);
        idle(8);
        chk("post_rst_part", 32'(frame_valid), 32'd0);

        sb.push_back({1'b0, 16'h9087});
        scan(7'h07, 7'h7F, 7'h3F, 7'h6F, 8);
        expect_frame(20);
        chk("post_rst_ovr", 32'(overrun), 32'd0);
        handshake();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
